// File: rtl/multiply_tokens_pkg.sv
// rtl/multiply_tokens_pkg.sv - shared sizing helpers for the token-rate multiplier
package multiply_tokens_pkg;

  // Largest factor a single input token can request.
  function automatic int max_factor(input int factor_w);
    return (1 << factor_w) - 1;
  endfunction

  // Width holding pending + factor without wrap.
  function automatic int sum_w(input int cnt_w, input int factor_w);
    return ((cnt_w > factor_w) ? cnt_w : factor_w) + 1;
  endfunction

endpackage

// File: rtl/multiply_tokens_sat_add_sub.sv
// rtl/multiply_tokens_sat_add_sub.sv - pending - dec + inc, clamped to the ceiling
module multiply_tokens_sat_add_sub
  import multiply_tokens_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int FACTOR_W    = 4,
  parameter int MAX_PENDING = (1 << CNT_W) - 1
) (
  input  logic [CNT_W-1:0]    pending,
  input  logic                dec,
  input  logic [FACTOR_W-1:0] inc,
  output logic [CNT_W-1:0]    result,
  output logic                saturate
);

  localparam int            SW   = sum_w(CNT_W, FACTOR_W);
  localparam logic [SW-1:0] CEIL = SW'(MAX_PENDING);

  logic          dec_eff;
  logic [SW-1:0] sum;

  always_comb begin
    // A decrement from zero would wrap; it cannot happen from the top, but keep the unit safe.
    dec_eff  = dec & (pending != '0);
    sum      = SW'(pending) + SW'(inc) - SW'(dec_eff);
    saturate = (sum > CEIL);
    result   = saturate ? CNT_W'(MAX_PENDING) : sum[CNT_W-1:0];
  end

endmodule

// File: rtl/multiply_tokens.sv
// rtl/multiply_tokens.sv - each token on a yields factor tokens on b, with saturation tracking
module multiply_tokens
  import multiply_tokens_pkg::*;
#(
  parameter int FACTOR_W    = 4,
  parameter int CNT_W       = 8,
  parameter int MAX_PENDING = (1 << CNT_W) - 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                a,
  input  logic [FACTOR_W-1:0] factor,
  input  logic                clear_ovf,
  output logic                b,
  output logic                a_ready,
  output logic                overflow,
  output logic [CNT_W-1:0]    pending
);

  localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(MAX_PENDING - max_factor(FACTOR_W));

  logic [FACTOR_W-1:0] inc;
  logic [CNT_W-1:0]    pending_next;
  logic                saturate;

  assign inc = a ? factor : '0;

  multiply_tokens_sat_add_sub #(
    .CNT_W       (CNT_W),
    .FACTOR_W    (FACTOR_W),
    .MAX_PENDING (MAX_PENDING)
  ) u_sat_add_sub (
    .pending  (pending),
    .dec      (b),
    .inc      (inc),
    .result   (pending_next),
    .saturate (saturate)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      pending <= pending_next;
      // A fresh saturation outranks a software clear in the same cycle.
      if (saturate)
        overflow <= 1'b1;
      else if (clear_ovf)
        overflow <= 1'b0;
    end
  end

  // Both outputs decode the register only, so a and factor never reach them combinationally.
  assign b       = (pending != '0);
  assign a_ready = (pending <= READY_MAX);

endmodule

// File: tb/tb_multiply_tokens.sv
// tb/tb_multiply_tokens.sv - directed vector table plus multi-cycle corner sequences
module tb_multiply_tokens;

  logic       clk = 1'b0;
  logic       rst;
  logic       a;
  logic [3:0] factor;
  logic       clear_ovf;
  logic       b;
  logic       a_ready;
  logic       overflow;
  logic [7:0] pending;

  int checks = 0;
  int errors = 0;

  multiply_tokens #(.FACTOR_W(4), .CNT_W(8), .MAX_PENDING(255)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .factor    (factor),
    .clear_ovf (clear_ovf),
    .b         (b),
    .a_ready   (a_ready),
    .overflow  (overflow),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       a;
    logic [3:0] factor;
    logic       clear_ovf;
    logic [7:0] exp_pending;
    logic       exp_b;
    logic       exp_ovf;
    logic       exp_ready;
  } vec_t;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic step(input logic va, input logic [3:0] vf, input logic vc);
    a         = va;
    factor    = vf;
    clear_ovf = vc;
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string name, input int ep, input int eb, input int eo, input int er);
    check({name, ".pending"}, int'(pending), ep);
    check({name, ".b"}, int'(b), eb);
    check({name, ".overflow"}, int'(overflow), eo);
    check({name, ".a_ready"}, int'(a_ready), er);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vecs[$];
    int   n_a;
    int   n_b;
    int   bcount;
    int   exp_p;

    // factor 5 single token, then 3 followed by 4 (with a dropped factor-0 token in the tail)
    vecs.push_back('{1'b1, 4'd5, 1'b0, 8'd5, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 4'd0, 1'b0, 8'd4, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 4'd0, 1'b0, 8'd3, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 4'd0, 1'b0, 8'd2, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 4'd0, 1'b0, 8'd1, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 4'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 4'd3, 1'b0, 8'd3, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 4'd4, 1'b0, 8'd6, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 4'd0, 1'b0, 8'd5, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 4'd0, 1'b0, 8'd4, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 4'd0, 1'b0, 8'd3, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 4'd0, 1'b0, 8'd2, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 4'd0, 1'b0, 8'd1, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 4'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1});

    rst = 1'b1; a = 1'b0; factor = 4'd0; clear_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 0, 0, 0, 1);
    rst = 1'b0;

    bcount = 0;
    foreach (vecs[i]) begin
      step(vecs[i].a, vecs[i].factor, vecs[i].clear_ovf);
      check_state($sformatf("vec%0d", i), vecs[i].exp_pending, vecs[i].exp_b,
                  vecs[i].exp_ovf, vecs[i].exp_ready);
      if (i >= 6) bcount += int'(b);
    end
    check("pair_b_total", bcount, 7);

    // factor 0 stream: tokens are accepted and dropped
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 4'd0, 1'b0);
      check_state("factor0", 0, 0, 0, 1);
    end

    // factor 2 random stream, then drain: totals conserved
    n_a = 0; n_b = 0;
    for (int i = 0; i < 400; i++) begin
      logic va;
      va = (i < 100) && ($urandom_range(99) < 30);
      n_a += int'(va);
      step(va, 4'd2, 1'b0);
      n_b += int'(b);
    end
    check("rand_b_total", n_b, 2 * n_a);
    check("rand_overflow", int'(overflow), 0);
    check("rand_pending", int'(pending), 0);

    // max-factor ramp into saturation
    for (int k = 1; k <= 19; k++) begin
      exp_p = (14 * k + 1 > 255) ? 255 : 14 * k + 1;
      step(1'b1, 4'd15, 1'b0);
      check_state($sformatf("ramp%0d", k), exp_p, 1, (k == 19) ? 1 : 0, (exp_p <= 240) ? 1 : 0);
    end

    // drain: exactly 255 owed tokens, flag stays sticky
    bcount = 0;
    for (int i = 0; i < 400 && b; i++) begin
      bcount++;
      step(1'b0, 4'd0, 1'b0);
    end
    check("drain_b_count", bcount, 255);
    check_state("drained", 0, 0, 1, 1);

    step(1'b0, 4'd0, 1'b1);
    check_state("clear_idle", 0, 0, 0, 1);

    // ramp again holding clear_ovf: saturation must win over clear
    for (int k = 1; k <= 20; k++) begin
      exp_p = (14 * k + 1 > 255) ? 255 : 14 * k + 1;
      step(1'b1, 4'd15, 1'b1);
      check_state($sformatf("clrramp%0d", k), exp_p, 1, (k >= 19) ? 1 : 0, (exp_p <= 240) ? 1 : 0);
    end

    // asynchronous reset mid-burst
    a = 1'b0; factor = 4'd0; clear_ovf = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_state("async_rst", 0, 0, 0, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bcount = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 4'd0, 1'b0);
      bcount += int'(b);
    end
    check("post_rst_b", bcount, 0);
    check("post_rst_pending", int'(pending), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiply_tokens.md
Name: multiply_tokens

Overview:
- Parametrised token-rate multiplier. Each 1-cycle token on `a` produces `factor` 1-cycle tokens on `b`.
- The multiplication factor is selectable per token at run time.
- Sits between token producers and consumers in the sequential-basics token pipeline. It is the generalised successor of the fixed ×2 token doubler.
- Adds a configurable counter width, a run-time factor, backpressure hint `a_ready`, a sticky saturating overflow flag with software clear, and a visible pending count.

Parameters:
- FACTOR_W, 4, width of the `factor` input; max factor is 2**FACTOR_W-1.
- CNT_W, 8, width of the internal pending-token counter.
- MAX_PENDING, 2**CNT_W-1, saturation ceiling of the pending counter. Legal range: 2**FACTOR_W-1 .. 2**CNT_W-1.

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- a  input  1  token in; one token per cycle when high.
- factor  input  FACTOR_W  number of output tokens for the token on `a`; sampled only when a=1.
- clear_ovf  input  1  synchronous clear of the sticky `overflow`.
- b  output  1  token out; at most one per cycle.
- a_ready  output  1  high when a max-factor token can be accepted without overflow.
- overflow  output  1  sticky; set when output tokens were lost to saturation.
- pending  output  CNT_W  output tokens still owed.

Behaviour:
- Reset (async, immediate): pending=0, overflow=0. Hence b=0 and a_ready=1 while rst is high. Owed tokens are discarded and not emitted after release.
- b = (pending != 0). Decoded from the register only; no combinational path from `a` or `factor`.
- Latency: a token at edge t makes b high at cycles t+1 .. t+factor, provided no saturation occurs.
- Next-state arithmetic in max(CNT_W,FACTOR_W)+1 bits, no wrap: sum = pending - b + (a ? factor : 0).
- If sum <= MAX_PENDING: pending <= sum.
- Else: pending <= MAX_PENDING and overflow <= 1. Tokens above the ceiling are lost.
- Simultaneous accept and emit is allowed in the same cycle; the net change is factor-1.
- a=1 with factor=0: token accepted and dropped. No b, no overflow, pending changes only by -b.
- a_ready = (pending <= MAX_PENDING - (2**FACTOR_W-1)). This is conservative: a source that only asserts `a` while a_ready=1 never causes overflow.
- a_ready is advisory. Tokens presented while a_ready=0 are still processed by the saturation rule.
- overflow clearing: clear_ovf=1 clears it next edge.
- If a saturation occurs in the same cycle as clear_ovf, set wins and overflow stays 1.
- rst has priority over everything.
- No other state; the block has no FSM beyond the counter and the flag.
- Totals conservation: with no saturation, total b tokens equals the sum of `factor` over all accepted tokens.

Decomposition:
- Package multiply_tokens_pkg holds:
  - function max_factor(FACTOR_W) returning 2**FACTOR_W-1;
  - function sum_w(CNT_W,FACTOR_W) giving the next-state arithmetic width.
- One natural sub-module: sat_add_sub. It is combinational, computing pending - dec + inc with clamp to MAX_PENDING and a saturate flag.
- The top holds the pending register, the overflow flag and the output decode.

Test Plan:
- factor=2, a random at 30% for 100 cycles, then a=0 for 300 cycles -> count(b) == 2*count(a), overflow=0, final pending=0.
- Single token, factor=5, at edge t -> pending reads 5,4,3,2,1,0 on edges t..t+5; b high exactly cycles t+1..t+5.
- Token at edge t with factor=3, another at t+1 with factor=4 -> pending 3 then 6 (3-1+4); 7 b-cycles total, contiguous.
- a=1, factor=0 for 10 cycles -> b never 1, pending stays 0, overflow=0.
- a=1, factor=15 continuously -> pending 15, 29, 43, ... with a_ready falling once pending>240. On the first sum>255: pending=255 and overflow=1. Then a=0 -> exactly 255 further b cycles.
- overflow=1, then:
  - clear_ovf=1 with a=0 -> overflow=0 next edge;
  - clear_ovf=1 on a saturating cycle -> overflow stays 1;
  - rst pulse mid-burst -> b=0, pending=0, overflow=0 immediately, no b after release.
